// File: rtl/iomem_fabric.sv
// PicoSoC iomem interconnect: registered page decode, one transaction at a time, bus-error on unmapped pages.
// Optional slave-timeout watchdog enabled by defining IOMEM_FABRIC_TIMEOUT_EN.
module iomem_fabric #(
  parameter int          NUM_SLAVES     = 4,
  parameter logic [7:0]  BASE_PAGE      = 8'h03,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     iomem_valid,
  output logic                     iomem_ready,
  input  logic [3:0]               iomem_wstrb,
  input  logic [31:0]              iomem_addr,
  input  logic [31:0]              iomem_wdata,
  output logic [31:0]              iomem_rdata,
  output logic [NUM_SLAVES-1:0]    s_valid,
  input  logic [NUM_SLAVES-1:0]    s_ready,
  input  logic [32*NUM_SLAVES-1:0] s_rdata,
  output logic [3:0]               s_wstrb,
  output logic [31:0]              s_addr,
  output logic [31:0]              s_wdata,
  output logic                     bus_err,
  output logic [7:0]               err_status
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;
  localparam logic [8:0] NS9      = 9'(NUM_SLAVES);

  if (NUM_SLAVES < 1 || NUM_SLAVES > 16) begin : g_bad_ns
    $error("iomem_fabric: NUM_SLAVES out of range");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_to
    $error("iomem_fabric: TIMEOUT_CYCLES out of range");
  end

  logic [1:0]            state_q, state_d;
  logic [NUM_SLAVES-1:0] svalid_q, svalid_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  ready_q, ready_d;
  logic                  berr_q, berr_d;
  logic                  pend_q, pend_d;
  logic [31:0]           addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic [3:0]            slot_q, slot_d;
  logic [7:0]            err_q, err_d;
`ifdef IOMEM_FABRIC_TIMEOUT_EN
  logic [15:0]           cnt_q, cnt_d;
`endif

  logic [7:0]  page_off;
  logic        mapped;
  logic [31:0] sel_rdata;
  logic        sel_ready;

  // Only the selected slot's ready/rdata are visible to the sequencer.
  always_comb begin
    sel_rdata = '0;
    sel_ready = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (slot_q == 4'(i)) begin
        sel_rdata = s_rdata[i*32 +: 32];
        sel_ready = s_ready[i];
      end
    end
  end

  always_comb begin
    page_off = iomem_addr[31:24] - BASE_PAGE;
    mapped   = {1'b0, page_off} < NS9;
    state_d  = state_q;
    svalid_d = svalid_q;
    rdata_d  = rdata_q;
    ready_d  = 1'b0;
    berr_d   = 1'b0;
    pend_d   = pend_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    slot_d   = slot_q;
    err_d    = err_q;
`ifdef IOMEM_FABRIC_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (iomem_valid) begin
          addr_d  = iomem_addr;
          wdata_d = iomem_wdata;
          wstrb_d = iomem_wstrb;
          slot_d  = page_off[3:0];
          if (mapped) begin
            for (int i = 0; i < NUM_SLAVES; i++) svalid_d[i] = (page_off == 8'(i));
            pend_d  = 1'b0;
            state_d = S_ACTIVE;
`ifdef IOMEM_FABRIC_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end else begin
            rdata_d  = ERR_DATA;
            err_d[6] = 1'b1;
            pend_d   = 1'b1;
            state_d  = S_RESP;
          end
        end
      end
      S_ACTIVE: begin
        // Ready is checked first so it wins over a coincident expiry.
        if (sel_ready) begin
          rdata_d  = sel_rdata;
          svalid_d = '0;
          pend_d   = 1'b0;
          state_d  = S_RESP;
        end
`ifdef IOMEM_FABRIC_TIMEOUT_EN
        else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
          svalid_d   = '0;
          rdata_d    = ERR_DATA;
          err_d[7]   = 1'b1;
          err_d[3:0] = slot_q;
          pend_d     = 1'b1;
          state_d    = S_RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      S_RESP: begin
        // First RESP cycle raises the pulse, second retires it; master drops valid meanwhile.
        if (!ready_q) begin
          ready_d = 1'b1;
          berr_d  = pend_q;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      svalid_q <= '0;
      rdata_q  <= '0;
      ready_q  <= 1'b0;
      berr_q   <= 1'b0;
      pend_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      slot_q   <= '0;
      err_q    <= '0;
`ifdef IOMEM_FABRIC_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      svalid_q <= svalid_d;
      rdata_q  <= rdata_d;
      ready_q  <= ready_d;
      berr_q   <= berr_d;
      pend_q   <= pend_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      slot_q   <= slot_d;
      err_q    <= err_d;
`ifdef IOMEM_FABRIC_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;
  assign bus_err     = berr_q;
  assign s_valid     = svalid_q;
  assign s_addr      = addr_q;
  assign s_wdata     = wdata_q;
  assign s_wstrb     = wstrb_q;
  assign err_status  = err_q;

endmodule

// File: tb/tb_iomem_fabric.sv
// Directed bench for iomem_fabric: vector table of single transactions plus multi-cycle corner sequences.
module tb_iomem_fabric;

`ifdef IOMEM_FABRIC_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         iomem_valid = 1'b0;
  logic         iomem_ready;
  logic [3:0]   iomem_wstrb = '0;
  logic [31:0]  iomem_addr = '0;
  logic [31:0]  iomem_wdata = '0;
  logic [31:0]  iomem_rdata;
  logic [3:0]   s_valid;
  logic [3:0]   s_ready = '0;
  logic [127:0] s_rdata = '0;
  logic [3:0]   s_wstrb;
  logic [31:0]  s_addr;
  logic [31:0]  s_wdata;
  logic         bus_err;
  logic [7:0]   err_status;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  iomem_fabric #(.NUM_SLAVES(4), .BASE_PAGE(8'h03), .TIMEOUT_CYCLES(8), .ERR_DATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .reset(reset), .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
    .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata),
    .iomem_rdata(iomem_rdata), .s_valid(s_valid), .s_ready(s_ready), .s_rdata(s_rdata),
    .s_wstrb(s_wstrb), .s_addr(s_addr), .s_wdata(s_wdata), .bus_err(bus_err),
    .err_status(err_status)
  );

  task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    int          slot;   // -1 = unmapped, no slave responds
    int          d;      // slave ready in the d-th cycle of s_valid (0 = never)
    logic [31:0] srd;
    bit          noise;  // hold ready high on every other slot
    logic [31:0] e_rd;
    logic        e_berr;
    int          e_lat;  // edges after the sampling edge until iomem_ready is seen
    logic [3:0]  e_sv;
    logic [7:0]  e_err;
  } vec_t;

  vec_t tv[8];

  task automatic run_txn(input logic [31:0] a, input logic [3:0] ws, input logic [31:0] wd,
                         input int slot, input int d, input logic [31:0] srd, input bit noise,
                         output logic [31:0] o_rd, output logic o_berr, output int o_lat,
                         output int o_nact, output logic [3:0] o_sv, output logic [67:0] o_cap,
                         output bit o_ovl);
    logic [3:0] hit;
    hit = (slot >= 0) ? 4'(1 << slot) : 4'b0;
    for (int i = 0; i < 4; i++) s_rdata[i*32 +: 32] = {16'hEE00, 16'(i)};
    if (slot >= 0) s_rdata[slot*32 +: 32] = srd;
    o_rd = '0; o_berr = 1'b0; o_lat = -1; o_nact = 0; o_sv = '0; o_cap = '0; o_ovl = 1'b0;
    iomem_addr = a; iomem_wstrb = ws; iomem_wdata = wd; iomem_valid = 1'b1;
    s_ready = noise ? ~hit : 4'b0;
    @(posedge clk);
    for (int t = 0; t < 60; t++) begin
      #1;
      if (t == 0) o_cap = {s_addr, s_wdata, s_wstrb};
      s_ready = noise ? ~hit : 4'b0;
      if (s_valid != 4'b0) begin
        o_sv = o_sv | s_valid;
        o_nact++;
        if (o_nact == d) s_ready = s_ready | hit;
      end
      if (iomem_ready) begin
        if (s_valid != 4'b0) o_ovl = 1'b1;
        o_rd = iomem_rdata; o_berr = bus_err; o_lat = t;
        break;
      end
      @(posedge clk);
    end
    @(posedge clk); #1;
    iomem_valid = 1'b0; s_ready = '0;
    if (o_lat >= 0) chk("ready_single_pulse", {67'b0, iomem_ready}, 68'd0);
    @(posedge clk); #1;
  endtask

  logic [31:0] rd;
  logic        be;
  int          lat, nact;
  logic [3:0]  sv;
  logic [67:0] cap;
  bit          ovl;

  initial begin
    tv[0] = '{32'h0400_0000, 4'h0, 32'h0,          1, 2, 32'h1234_5678, 1'b1, 32'h1234_5678, 1'b0, 3, 4'b0010, 8'h00};
    tv[1] = '{32'h0300_0004, 4'hF, 32'hA5A5_A5A5,  0, 1, 32'h0000_1111, 1'b0, 32'h0000_1111, 1'b0, 2, 4'b0001, 8'h00};
    tv[2] = '{32'h0600_0010, 4'h0, 32'h0,          3, 3, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D, 1'b0, 4, 4'b1000, 8'h00};
    tv[3] = '{32'h0500_0008, 4'h3, 32'h0000_BEEF,  2, 1, 32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D, 1'b0, 2, 4'b0100, 8'h00};
    tv[4] = '{32'h0700_0000, 4'h0, 32'h0,         -1, 0, 32'h0,         1'b0, 32'hDEAD_BEEF, 1'b1, 1, 4'b0000, 8'h40};
    tv[5] = '{32'h0200_0000, 4'h0, 32'h0,         -1, 0, 32'h0,         1'b0, 32'hDEAD_BEEF, 1'b1, 1, 4'b0000, 8'h40};
    tv[6] = '{32'hFF00_0040, 4'h1, 32'h0000_0077, -1, 0, 32'h0,         1'b0, 32'hDEAD_BEEF, 1'b1, 1, 4'b0000, 8'h40};
    tv[7] = '{32'h0400_0000, 4'h0, 32'h0,          1, 1, 32'h55AA_55AA, 1'b0, 32'h55AA_55AA, 1'b0, 2, 4'b0010, 8'h40};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_valid", {64'b0, s_valid}, 68'd0);
    chk("rst_ready_err", {66'b0, iomem_ready, bus_err}, 68'd0);
    chk("rst_rdata", {36'b0, iomem_rdata}, 68'd0);
    chk("rst_sregs", {s_addr, s_wdata, s_wstrb}, 68'd0);
    chk("rst_err_status", {60'b0, err_status}, 68'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 8; v++) begin
      run_txn(tv[v].addr, tv[v].wstrb, tv[v].wdata, tv[v].slot, tv[v].d, tv[v].srd, tv[v].noise,
              rd, be, lat, nact, sv, cap, ovl);
      chk($sformatf("v%0d_rdata", v), {36'b0, rd}, {36'b0, tv[v].e_rd});
      chk($sformatf("v%0d_bus_err", v), {67'b0, be}, {67'b0, tv[v].e_berr});
      chk($sformatf("v%0d_latency", v), {36'b0, 32'(lat)}, {36'b0, 32'(tv[v].e_lat)});
      chk($sformatf("v%0d_s_valid", v), {64'b0, sv}, {64'b0, tv[v].e_sv});
      chk($sformatf("v%0d_capture", v), cap, {tv[v].addr, tv[v].wdata, tv[v].wstrb});
      chk($sformatf("v%0d_overlap", v), {67'b0, ovl}, 68'd0);
      chk($sformatf("v%0d_err_status", v), {60'b0, err_status}, {60'b0, tv[v].e_err});
    end

    // Slave holds ready for several cycles while its rdata changes: only the first cycle counts.
    begin
      int pulses;
      logic [31:0] got;
      logic        sv_after;
      pulses = 0; got = '0; sv_after = 1'b0;
      s_rdata[31:0] = 32'h1111_0001;
      iomem_addr = 32'h0300_0000; iomem_wstrb = 4'h0; iomem_valid = 1'b1;
      @(posedge clk); #1;
      s_ready = 4'b0001;
      @(posedge clk); #1;
      s_rdata[31:0] = 32'h2222_0002;
      for (int c = 0; c < 6; c++) begin
        @(posedge clk); #1;
        if (pulses > 0) iomem_valid = 1'b0;
        if (iomem_ready) begin pulses++; got = iomem_rdata; end
        if (pulses > 0 && s_valid != 4'b0) sv_after = 1'b1;
      end
      s_ready = '0;
      chk("hold_pulses", {36'b0, 32'(pulses)}, 68'd1);
      chk("hold_rdata", {36'b0, got}, {36'b0, 32'h1111_0001});
      chk("hold_no_restart", {67'b0, sv_after}, 68'd0);
    end

    // Reset while slot 1 is selected aborts without a response.
    begin
      bit rdy_seen;
      rdy_seen = 1'b0;
      iomem_addr = 32'h0400_0000; iomem_wstrb = 4'h0; iomem_wdata = 32'h0; iomem_valid = 1'b1;
      @(posedge clk); #1;
      chk("rstmid_s_valid_before", {64'b0, s_valid}, {64'b0, 4'b0010});
      reset = 1'b1; iomem_valid = 1'b0;
      @(posedge clk); #1;
      chk("rstmid_s_valid", {64'b0, s_valid}, 68'd0);
      chk("rstmid_ready_err", {66'b0, iomem_ready, bus_err}, 68'd0);
      chk("rstmid_rdata", {36'b0, iomem_rdata}, 68'd0);
      chk("rstmid_sregs", {s_addr, s_wdata, s_wstrb}, 68'd0);
      chk("rstmid_err_status", {60'b0, err_status}, 68'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      for (int c = 0; c < 4; c++) begin
        @(posedge clk); #1;
        if (iomem_ready) rdy_seen = 1'b1;
      end
      chk("rstmid_no_ready", {67'b0, rdy_seen}, 68'd0);
      run_txn(32'h0400_0000, 4'h0, 32'h0, 1, 1, 32'h0F0F_0F0F, 1'b0, rd, be, lat, nact, sv, cap, ovl);
      chk("post_rst_rdata", {36'b0, rd}, {36'b0, 32'h0F0F_0F0F});
      chk("post_rst_latency", {36'b0, 32'(lat)}, 68'd2);
      chk("post_rst_bus_err", {67'b0, be}, 68'd0);
    end

    // Slot 2 never answers (watchdog build) or answers late (no watchdog).
    run_txn(32'h0500_0000, 4'h0, 32'h0, 2, TO_EN ? 0 : 20, 32'h2222_4444, 1'b0,
            rd, be, lat, nact, sv, cap, ovl);
    chk("to_s_valid_cycles", {36'b0, 32'(nact)}, {36'b0, TO_EN ? 32'd8 : 32'd20});
    chk("to_latency", {36'b0, 32'(lat)}, {36'b0, TO_EN ? 32'd9 : 32'd21});
    chk("to_bus_err", {67'b0, be}, {67'b0, TO_EN});
    chk("to_rdata", {36'b0, rd}, {36'b0, TO_EN ? 32'hDEAD_BEEF : 32'h2222_4444});
    chk("to_s_valid", {64'b0, sv}, {64'b0, 4'b0100});
    chk("to_err_status", {60'b0, err_status}, {60'b0, TO_EN ? 8'h82 : 8'h00});

    // Slot 3 ready in the same cycle the counter would expire: normal completion.
    run_txn(32'h0600_0000, 4'h0, 32'h0, 3, 8, 32'h3333_7777, 1'b0, rd, be, lat, nact, sv, cap, ovl);
    chk("exp_rdata", {36'b0, rd}, {36'b0, 32'h3333_7777});
    chk("exp_bus_err", {67'b0, be}, 68'd0);
    chk("exp_latency", {36'b0, 32'(lat)}, 68'd9);
    chk("exp_err_status", {60'b0, err_status}, {60'b0, TO_EN ? 8'h82 : 8'h00});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
